// File: rtl/target_pkg.sv
// Shared types and default constants for the target track file.
package target_pkg;

    localparam int DEF_N_TGT = 16;
    localparam int DEF_CW    = 8;
    localparam int DEF_AGE_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Track coordinates at the default width; x occupies the most significant field.
    typedef struct packed {
        logic [DEF_CW-1:0] x;
        logic [DEF_CW-1:0] y;
        logic [DEF_CW-1:0] z;
        logic [DEF_CW-1:0] t;
    } coord_t;

endpackage

// File: rtl/target_track_file_if.sv
// Write/read/status bundle of the target track file; rd_age exists only with TARGET_TRACK_AGE_EN.
interface target_track_file_if #(
    parameter int N_TGT = 16,
    parameter int CW    = 8
`ifdef TARGET_TRACK_AGE_EN
    , parameter int AGE_W = 8
`endif
);
    localparam int IW = $clog2(N_TGT);
    localparam int VW = $clog2(N_TGT + 1);

    logic          clr;
    logic          wr_valid;
    logic          wr_ready;
    logic [IW-1:0] wr_tgt;
    logic [CW-1:0] wr_x;
    logic [CW-1:0] wr_y;
    logic [CW-1:0] wr_z;
    logic [CW-1:0] wr_t;
    logic          rd_en;
    logic [IW-1:0] rd_tgt;
    logic          rd_valid;
    logic          rd_hit;
    logic [CW-1:0] rd_x;
    logic [CW-1:0] rd_y;
    logic [CW-1:0] rd_z;
    logic [CW-1:0] rd_t;
    logic          busy;
    logic [VW-1:0] valid_cnt;
    logic          wr_err;
`ifdef TARGET_TRACK_AGE_EN
    logic [AGE_W-1:0] rd_age;
`endif

    modport master (
        output clr, wr_valid, wr_tgt, wr_x, wr_y, wr_z, wr_t, rd_en, rd_tgt,
        input  wr_ready, rd_valid, rd_hit, rd_x, rd_y, rd_z, rd_t, busy, valid_cnt, wr_err
`ifdef TARGET_TRACK_AGE_EN
        , input rd_age
`endif
    );

    modport slave (
        input  clr, wr_valid, wr_tgt, wr_x, wr_y, wr_z, wr_t, rd_en, rd_tgt,
        output wr_ready, rd_valid, rd_hit, rd_x, rd_y, rd_z, rd_t, busy, valid_cnt, wr_err
`ifdef TARGET_TRACK_AGE_EN
        , output rd_age
`endif
    );

endinterface

// File: rtl/target_entry.sv
// One track slot: coordinates, valid flag and, with TARGET_TRACK_AGE_EN, a saturating age counter.
module target_entry #(
    parameter int CW = 8
`ifdef TARGET_TRACK_AGE_EN
    , parameter int AGE_W = 8
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [4*CW-1:0] wr_coord,
    input  logic            clr_en,
    output logic            valid,
    output logic [4*CW-1:0] coord
`ifdef TARGET_TRACK_AGE_EN
    , output logic [AGE_W-1:0] age
`endif
);

    logic            valid_reg;
    logic [4*CW-1:0] coord_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            coord_reg <= '0;
        end else if (wr_en) begin
            valid_reg <= 1'b1;
            coord_reg <= wr_coord;
        end else if (clr_en) begin
            valid_reg <= 1'b0;
        end
    end

`ifdef TARGET_TRACK_AGE_EN
    logic [AGE_W-1:0] age_reg;

    // Age counts edges since the last write while the slot holds a track.
    always_ff @(posedge clk) begin
        if (!rst) begin
            age_reg <= '0;
        end else if (wr_en) begin
            age_reg <= '0;
        end else if (valid_reg && (age_reg != '1)) begin
            age_reg <= age_reg + 1'b1;
        end
    end

    assign age = age_reg;
`endif

    assign valid = valid_reg;
    assign coord = coord_reg;

endmodule

// File: rtl/target_track_file.sv
// Target track store with a clear-all sweep FSM and 1-cycle registered reads.
// Define TARGET_TRACK_AGE_EN to add per-entry age counters and the rd_age output.
module target_track_file
    import target_pkg::*;
#(
    parameter int N_TGT = DEF_N_TGT,
    parameter int CW    = DEF_CW,
    parameter int AGE_W = DEF_AGE_W
) (
    input  logic               clk,
    input  logic               rst,
    target_track_file_if.slave bus
);

    localparam int IW = $clog2(N_TGT);
    localparam int NP = 2 ** IW;
    localparam int VW = $clog2(N_TGT + 1);
    localparam logic [IW:0]   N_LIM    = (IW + 1)'(N_TGT);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_TGT - 1);
    localparam logic [VW-1:0] CNT_MAX  = VW'(N_TGT);

    generate
        if (N_TGT < 2 || N_TGT > 64 || CW < 1 || AGE_W < 1) begin : g_bad_cfg
            $error("target_track_file: unsupported parameter set");
        end
    endgenerate

    state_t          state_reg, state_next;
    logic [IW-1:0]   sweep_idx_reg, sweep_idx_next;
    logic            busy, wr_ready, wr_fire, wr_in_range;
    logic [4*CW-1:0] wr_coord;
    logic [NP-1:0]   valid_pad, wr_sel, clr_sel;
    logic [4*CW-1:0] coord_pad [NP];
    logic [VW-1:0]   valid_cnt_reg;
    logic            cnt_inc, cnt_dec;
    logic            wr_err_reg, rd_valid_reg, rd_hit_reg;
    logic [4*CW-1:0] rd_coord_reg;
`ifdef TARGET_TRACK_AGE_EN
    logic [AGE_W-1:0] age_pad [NP];
    logic [AGE_W-1:0] rd_age_reg;
`endif

    assign busy        = (state_reg == CLEAR);
    assign wr_ready    = (state_reg == IDLE) && !bus.clr;
    assign wr_fire     = bus.wr_valid && wr_ready;
    assign wr_in_range = {1'b0, bus.wr_tgt} < N_LIM;
    assign wr_coord    = {bus.wr_x, bus.wr_y, bus.wr_z, bus.wr_t};

    always_comb begin
        state_next     = state_reg;
        sweep_idx_next = sweep_idx_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clr) begin
                    state_next     = CLEAR;
                    sweep_idx_next = '0;
                end
            end
            CLEAR: begin
                if (sweep_idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    sweep_idx_next = sweep_idx_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slots are padded to a power of two so any read index resolves to an empty slot.
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_slot
            if (gi < N_TGT) begin : g_entry
                assign wr_sel[gi]  = wr_fire && (bus.wr_tgt == IW'(gi));
                assign clr_sel[gi] = busy && (sweep_idx_reg == IW'(gi));
                target_entry #(
                    .CW(CW)
`ifdef TARGET_TRACK_AGE_EN
                    , .AGE_W(AGE_W)
`endif
                ) u_entry (
                    .clk      (clk),
                    .rst      (rst),
                    .wr_en    (wr_sel[gi]),
                    .wr_coord (wr_coord),
                    .clr_en   (clr_sel[gi]),
                    .valid    (valid_pad[gi]),
                    .coord    (coord_pad[gi])
`ifdef TARGET_TRACK_AGE_EN
                    , .age    (age_pad[gi])
`endif
                );
            end else begin : g_pad
                assign wr_sel[gi]    = 1'b0;
                assign clr_sel[gi]   = 1'b0;
                assign valid_pad[gi] = 1'b0;
                assign coord_pad[gi] = '0;
`ifdef TARGET_TRACK_AGE_EN
                assign age_pad[gi]   = '0;
`endif
            end
        end
    endgenerate

    assign cnt_inc = |(wr_sel & ~valid_pad);
    assign cnt_dec = |(clr_sel & valid_pad);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            sweep_idx_reg <= '0;
            valid_cnt_reg <= '0;
            wr_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sweep_idx_reg <= sweep_idx_next;
            wr_err_reg    <= wr_fire && !wr_in_range;
            if (cnt_inc && (valid_cnt_reg != CNT_MAX)) begin
                valid_cnt_reg <= valid_cnt_reg + 1'b1;
            end else if (cnt_dec && (valid_cnt_reg != '0)) begin
                valid_cnt_reg <= valid_cnt_reg - 1'b1;
            end
        end
    end

    // Slots update on the same edge, so a colliding read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_reg <= 1'b0;
            rd_hit_reg   <= 1'b0;
            rd_coord_reg <= '0;
`ifdef TARGET_TRACK_AGE_EN
            rd_age_reg   <= '0;
`endif
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                rd_hit_reg   <= valid_pad[bus.rd_tgt];
                rd_coord_reg <= valid_pad[bus.rd_tgt] ? coord_pad[bus.rd_tgt] : '0;
`ifdef TARGET_TRACK_AGE_EN
                rd_age_reg   <= valid_pad[bus.rd_tgt] ? age_pad[bus.rd_tgt] : '0;
`endif
            end
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.busy      = busy;
    assign bus.valid_cnt = valid_cnt_reg;
    assign bus.wr_err    = wr_err_reg;
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.rd_hit    = rd_hit_reg;
    assign bus.rd_x      = rd_coord_reg[4*CW-1:3*CW];
    assign bus.rd_y      = rd_coord_reg[3*CW-1:2*CW];
    assign bus.rd_z      = rd_coord_reg[2*CW-1:CW];
    assign bus.rd_t      = rd_coord_reg[CW-1:0];
`ifdef TARGET_TRACK_AGE_EN
    assign bus.rd_age    = rd_age_reg;
`endif

endmodule

// File: tb/tb_target_track_file.sv
// Bench for target_track_file: a 16-entry and a 12-entry instance checked every cycle against a model.
module tb_target_track_file;
    import target_pkg::*;

    localparam int NA  = 16;
    localparam int NB  = 12;
    localparam int CWT = 8;
    localparam int AWT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    target_track_file_if #(.N_TGT(NA), .CW(CWT)
`ifdef TARGET_TRACK_AGE_EN
        , .AGE_W(AWT)
`endif
    ) ia ();
    target_track_file_if #(.N_TGT(NB), .CW(CWT)
`ifdef TARGET_TRACK_AGE_EN
        , .AGE_W(AWT)
`endif
    ) ib ();

    target_track_file #(.N_TGT(NA), .CW(CWT), .AGE_W(AWT)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    target_track_file #(.N_TGT(NB), .CW(CWT), .AGE_W(AWT)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: what each table holds, how much sweep remains, and what the last read must show.
    logic   m_valid [2][64];
    coord_t m_coord [2][64];
    int     m_left  [2];
    int     m_idx   [2];
    logic   e_rd_valid [2];
    logic   e_rd_hit   [2];
    coord_t e_rd       [2];
    logic   e_wr_err   [2];
`ifdef TARGET_TRACK_AGE_EN
    logic [AWT-1:0] m_age [2][64];
    logic [AWT-1:0] e_age [2];
`endif

    logic   s_clr [2], s_wv [2], s_re [2];
    int     s_wt [2], s_rt [2];
    coord_t s_wc [2];

    always_comb begin
        s_clr[0] = ia.clr; s_wv[0] = ia.wr_valid; s_re[0] = ia.rd_en;
        s_wt[0]  = int'(ia.wr_tgt); s_rt[0] = int'(ia.rd_tgt);
        s_wc[0]  = {ia.wr_x, ia.wr_y, ia.wr_z, ia.wr_t};
        s_clr[1] = ib.clr; s_wv[1] = ib.wr_valid; s_re[1] = ib.rd_en;
        s_wt[1]  = int'(ib.wr_tgt); s_rt[1] = int'(ib.rd_tgt);
        s_wc[1]  = {ib.wr_x, ib.wr_y, ib.wr_z, ib.wr_t};
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int n      = (d == 0) ? NA : NB;
            automatic bit busy_m = (m_left[d] != 0);
            automatic bit acc    = s_wv[d] && !busy_m && !s_clr[d];
            automatic bit hit    = (s_rt[d] < n) && (m_valid[d][s_rt[d]] === 1'b1);
            if (!rst) begin
                for (int i = 0; i < 64; i++) begin
                    m_valid[d][i] <= 1'b0;
                    m_coord[d][i] <= '0;
`ifdef TARGET_TRACK_AGE_EN
                    m_age[d][i]   <= '0;
`endif
                end
                m_left[d] <= 0; m_idx[d] <= 0;
                e_rd_valid[d] <= 1'b0; e_rd_hit[d] <= 1'b0; e_rd[d] <= '0; e_wr_err[d] <= 1'b0;
`ifdef TARGET_TRACK_AGE_EN
                e_age[d] <= '0;
`endif
            end else begin
`ifdef TARGET_TRACK_AGE_EN
                for (int i = 0; i < n; i++)
                    if (m_valid[d][i] === 1'b1 && m_age[d][i] != '1) m_age[d][i] <= m_age[d][i] + 1'b1;
`endif
                e_wr_err[d] <= acc && (s_wt[d] >= n);
                if (acc && s_wt[d] < n) begin
                    m_valid[d][s_wt[d]] <= 1'b1;
                    m_coord[d][s_wt[d]] <= s_wc[d];
`ifdef TARGET_TRACK_AGE_EN
                    m_age[d][s_wt[d]]   <= '0;
`endif
                end
                if (busy_m) begin
                    m_valid[d][m_idx[d]] <= 1'b0;
                    m_idx[d]  <= m_idx[d] + 1;
                    m_left[d] <= m_left[d] - 1;
                end else if (s_clr[d]) begin
                    m_left[d] <= n;
                    m_idx[d]  <= 0;
                end
                e_rd_valid[d] <= s_re[d];
                if (s_re[d]) begin
                    e_rd_hit[d] <= hit;
                    e_rd[d]     <= hit ? m_coord[d][s_rt[d]] : '0;
`ifdef TARGET_TRACK_AGE_EN
                    e_age[d]    <= hit ? m_age[d][s_rt[d]] : '0;
`endif
                end
            end
        end
    end

    function automatic int popcnt(input int d);
        int c = 0;
        for (int i = 0; i < 64; i++) if (m_valid[d][i] === 1'b1) c++;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("a.busy",      ia.busy, m_left[0] != 0);
        chk("a.wr_ready",  ia.wr_ready, (m_left[0] == 0) && !ia.clr);
        chk("a.valid_cnt", ia.valid_cnt, popcnt(0));
        chk("a.rd_valid",  ia.rd_valid, e_rd_valid[0]);
        chk("a.rd_hit",    ia.rd_hit, e_rd_hit[0]);
        chk("a.rd_data",   {ia.rd_x, ia.rd_y, ia.rd_z, ia.rd_t}, e_rd[0]);
        chk("a.wr_err",    ia.wr_err, e_wr_err[0]);
        chk("b.busy",      ib.busy, m_left[1] != 0);
        chk("b.wr_ready",  ib.wr_ready, (m_left[1] == 0) && !ib.clr);
        chk("b.valid_cnt", ib.valid_cnt, popcnt(1));
        chk("b.rd_valid",  ib.rd_valid, e_rd_valid[1]);
        chk("b.rd_hit",    ib.rd_hit, e_rd_hit[1]);
        chk("b.rd_data",   {ib.rd_x, ib.rd_y, ib.rd_z, ib.rd_t}, e_rd[1]);
        chk("b.wr_err",    ib.wr_err, e_wr_err[1]);
`ifdef TARGET_TRACK_AGE_EN
        chk("a.rd_age",    ia.rd_age, e_age[0]);
        chk("b.rd_age",    ib.rd_age, e_age[1]);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_en) compare_all();
    endtask

    task automatic idle_all();
        ia.clr = 1'b0; ia.wr_valid = 1'b0; ia.rd_en = 1'b0; ia.wr_tgt = '0; ia.rd_tgt = '0;
        ia.wr_x = '0; ia.wr_y = '0; ia.wr_z = '0; ia.wr_t = '0;
        ib.clr = 1'b0; ib.wr_valid = 1'b0; ib.rd_en = 1'b0; ib.wr_tgt = '0; ib.rd_tgt = '0;
        ib.wr_x = '0; ib.wr_y = '0; ib.wr_z = '0; ib.wr_t = '0;
    endtask

    task automatic set_wr_a(input logic [3:0] tgt, input coord_t c);
        ia.wr_valid = 1'b1; ia.wr_tgt = tgt;
        ia.wr_x = c.x; ia.wr_y = c.y; ia.wr_z = c.z; ia.wr_t = c.t;
    endtask

    task automatic wr_a(input logic [3:0] tgt, input coord_t c);
        set_wr_a(tgt, c);
        tick();
        ia.wr_valid = 1'b0;
    endtask

    task automatic rd_a(input logic [3:0] tgt);
        ia.rd_en = 1'b1; ia.rd_tgt = tgt;
        tick();
        ia.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_all();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        idle_all();
        repeat (2) tick();
        chk_en = 1'b1;
        tick();
        chk("reset.valid_cnt", ia.valid_cnt, 0);
        chk("reset.busy", ia.busy, 0);
        chk("reset.rd_valid", ia.rd_valid, 0);
        rst = 1'b1;

        // Basic write then read
        wr_a(4'd3, 32'h0A141E28);
        rd_a(4'd3);
        chk("t1.rd_valid", ia.rd_valid, 1);
        chk("t1.rd_hit", ia.rd_hit, 1);
        chk("t1.rd_data", {ia.rd_x, ia.rd_y, ia.rd_z, ia.rd_t}, 32'h0A141E28);
        chk("t1.valid_cnt", ia.valid_cnt, 1);
        tick();
        chk("t1.hold_valid", ia.rd_valid, 0);
        chk("t1.hold_data", {ia.rd_x, ia.rd_y, ia.rd_z, ia.rd_t}, 32'h0A141E28);

        // Double write to one slot, read an empty slot
        do_reset();
        wr_a(4'd5, 32'h01020304);
        wr_a(4'd5, 32'h05060708);
        rd_a(4'd7);
        chk("t2.valid_cnt", ia.valid_cnt, 1);
        chk("t2.miss_hit", ia.rd_hit, 0);
        chk("t2.miss_data", {ia.rd_x, ia.rd_y, ia.rd_z, ia.rd_t}, 0);
        rd_a(4'd5);
        chk("t2.rewrite_data", {ia.rd_x, ia.rd_y, ia.rd_z, ia.rd_t}, 32'h05060708);

        // Out-of-range write on the 12-entry instance
        ib.wr_valid = 1'b1; ib.wr_tgt = 4'd13; ib.wr_x = 8'hAA;
        tick();
        ib.wr_valid = 1'b0;
        chk("t3.wr_err_pulse", ib.wr_err, 1);
        chk("t3.valid_cnt", ib.valid_cnt, 0);
        tick();
        chk("t3.wr_err_end", ib.wr_err, 0);
        ib.wr_valid = 1'b1; ib.wr_tgt = 4'd11;
        tick();
        ib.wr_valid = 1'b0;
        chk("t3.last_wr_err", ib.wr_err, 0);
        chk("t3.last_cnt", ib.valid_cnt, 1);
        ib.rd_en = 1'b1; ib.rd_tgt = 4'd13;
        tick();
        ib.rd_en = 1'b0;
        chk("t3.oor_rd_hit", ib.rd_hit, 0);

        // Same-cycle read and write of one slot
        do_reset();
        wr_a(4'd2, 32'h01010101);
        set_wr_a(4'd2, 32'h09090909);
        ia.rd_en = 1'b1; ia.rd_tgt = 4'd2;
        tick();
        ia.wr_valid = 1'b0; ia.rd_en = 1'b0;
        chk("t5.rbw_old", {ia.rd_x, ia.rd_y, ia.rd_z, ia.rd_t}, 32'h01010101);
        rd_a(4'd2);
        chk("t5.rbw_new", {ia.rd_x, ia.rd_y, ia.rd_z, ia.rd_t}, 32'h09090909);

        // Fill all slots then sweep, with a write held off, reads mid-sweep and a second clr
        do_reset();
        for (int i = 0; i < NA; i++) wr_a(4'(i), {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)});
        chk("t4.full_cnt", ia.valid_cnt, 16);
        ia.clr = 1'b1;
        tick();
        ia.clr = 1'b0;
        busy_cycles = 0;
        set_wr_a(4'd0, 32'h77777777);
        for (int c = 0; c < 40 && ia.busy; c++) begin
            busy_cycles++;
            if (c == 8) chk("t4.mid_cnt", ia.valid_cnt, 8);
            ia.clr    = (c == 5);
            ia.rd_en  = (c == 3) || (c == 4);
            ia.rd_tgt = (c == 3) ? 4'd0 : 4'd15;
            tick();
        end
        ia.clr = 1'b0; ia.wr_valid = 1'b0; ia.rd_en = 1'b0;
        chk("t4.busy_cycles", busy_cycles, 16);
        chk("t4.final_cnt", ia.valid_cnt, 0);

        // Reset during a sweep discards the write presented in the reset cycle
        wr_a(4'd1, 32'h11223344);
        ia.clr = 1'b1;
        tick();
        ia.clr = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        set_wr_a(4'd6, 32'h66666666);
        tick();
        rst = 1'b1; ia.wr_valid = 1'b0;
        chk("t6.busy_after_rst", ia.busy, 0);
        chk("t6.cnt_after_rst", ia.valid_cnt, 0);
        rd_a(4'd6);
        chk("t6.discarded_wr", ia.rd_hit, 0);

`ifdef TARGET_TRACK_AGE_EN
        // Age saturates at 15 for a 4-bit counter; one idle edge after a rewrite gives 1
        do_reset();
        wr_a(4'd0, 32'h01020304);
        repeat (20) tick();
        rd_a(4'd0);
        chk("t7.age_sat", ia.rd_age, 15);
        wr_a(4'd0, 32'h05060708);
        tick();
        rd_a(4'd0);
        chk("t7.age_rewrite", ia.rd_age, 1);
        rd_a(4'd9);
        chk("t7.age_miss", ia.rd_age, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/target_track_file.md
TARGET_TRACK_FILE -- requirements
Module: target_track_file

Interface
REQ-001 SHALL have parameter N_TGT, default 16: number of target entries (2..64).
REQ-002 SHALL have parameter CW, default 8: width of each coordinate (X, Y, Z, T).
REQ-003 SHALL have parameter AGE_W, default 8: age counter width (used only with TRACK_AGE_EN).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port clr, input, 1: start clear-all sweep.
REQ-007 SHALL have port wr_valid, input, 1: write request.
REQ-008 SHALL have port wr_ready, output, 1: write accepted when wr_valid && wr_ready.
REQ-009 SHALL have port wr_tgt, input, IW = $clog2(N_TGT): write target index.
REQ-010 SHALL have ports wr_x, wr_y, wr_z, wr_t, input, CW each: coordinates to store.
REQ-011 SHALL have port rd_en, input, 1: read request; port rd_tgt, input, IW: read index.
REQ-012 SHALL have port rd_valid, output, 1: read data valid; port rd_hit, output, 1: entry holds a track.
REQ-013 SHALL have ports rd_x, rd_y, rd_z, rd_t, output, CW each: read coordinates.
REQ-014 SHALL have port busy, output, 1: clear sweep in progress.
REQ-015 SHALL have port valid_cnt, output, $clog2(N_TGT+1): count of valid entries.
REQ-016 SHALL have port wr_err, output, 1: one-cycle pulse on accepted write with wr_tgt >= N_TGT.

Function
REQ-017 SHALL implement states IDLE and CLEAR; IDLE->CLEAR on clr in IDLE; CLEAR->IDLE after entry N_TGT-1 is cleared.
REQ-018 In CLEAR, the sweep SHALL clear the valid bit of one entry per cycle, index 0 upward, taking exactly N_TGT cycles.
REQ-019 clr asserted in CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-020 wr_ready SHALL equal (state==IDLE) && !clr.
REQ-021 An accepted write with wr_tgt < N_TGT SHALL update all four coordinates of that entry and set its valid bit at the next edge.
REQ-022 An accepted write with wr_tgt >= N_TGT SHALL change no entry and SHALL pulse wr_err for one cycle on the next cycle.
REQ-023 Read latency SHALL be 1 cycle: rd_en at edge k gives rd_valid=1 and data after edge k; without rd_en, rd_valid=0 and data holds.
REQ-024 A read and a write to the same entry in the same cycle SHALL return the pre-write contents (read-before-write).
REQ-025 A read of an invalid or out-of-range entry SHALL give rd_hit=0 and zero coordinates.
REQ-026 Reads SHALL be served in both states; an entry already swept SHALL read rd_hit=0.
REQ-027 valid_cnt SHALL increment only when a write sets a previously clear valid bit.
REQ-028 valid_cnt SHALL decrement only when the sweep clears a previously set bit.
REQ-029 valid_cnt SHALL never wrap.

Reset
REQ-030 When rst=0 at an edge, the block SHALL set state to IDLE and clear all valid bits and all coordinates.
REQ-031 The same reset SHALL give valid_cnt=0, rd_valid=0, rd_hit=0, rd_x..rd_t=0, wr_err=0, busy=0, and (if enabled) rd_age=0 and all ages 0.
REQ-032 Reset during CLEAR SHALL abort the sweep; a write or read in the reset cycle SHALL be discarded.

Configuration
REQ-033 With macro TARGET_TRACK_AGE_EN defined, each entry SHALL hold an AGE_W age counter.
REQ-034 The age counter SHALL load 0 on write and otherwise increment each cycle while valid, saturating at 2^AGE_W-1.
REQ-035 The age SHALL be presented on output rd_age (AGE_W) with read timing (1 cycle, 0 on miss).
REQ-036 Without TARGET_TRACK_AGE_EN, port rd_age and all age logic SHALL be absent.

Structure
REQ-037 A shared package target_pkg SHALL hold the coord_t record {x,y,z,t} with CW-wide fields, the IDLE/CLEAR state enum and default parameter constants.
REQ-038 One sub-module target_entry (storage + valid + optional age for one target) SHALL be instantiated N_TGT times by generate.

Verification
REQ-039 Test: reset, write tgt 3 = (10,20,30,40), read tgt 3 -> next cycle rd_valid=1, rd_hit=1, data (10,20,30,40), valid_cnt=1.
REQ-040 Test: write tgt 5 twice, then read tgt 7 -> valid_cnt=1 and tgt 7 gives rd_hit=0 with zero coordinates.
REQ-041 Test: N_TGT=12, write tgt 13 -> wr_err pulses 1 cycle, valid_cnt unchanged.
REQ-042 Test: fill 16 entries, pulse clr -> busy high 16 cycles, wr_ready low throughout, valid_cnt steps 16->0, second clr mid-sweep ignored.
REQ-043 Test: write tgt 2 = (1,1,1,1), then same-cycle read and write tgt 2 = (9,9,9,9) -> read returns (1,1,1,1), the following read returns (9,9,9,9).
REQ-044 Test: with TARGET_TRACK_AGE_EN and AGE_W=4, write tgt 0, wait 20 cycles, read -> rd_age=15; rewrite then read -> rd_age=1.
